// File: rtl/apb_pkg.sv
// apb_pkg: shared APB4 completer definitions.
// Contents: bus widths, the completer FSM state enum, and a byte-lane merge
// helper used to apply strobed writes to a stored word.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Replace each byte lane of old_word with the matching wdata lane where strb is set.
  function automatic logic [APB_DATA_W-1:0] merge_bytes(
    input logic [APB_DATA_W-1:0] old_word,
    input logic [APB_DATA_W-1:0] wdata,
    input logic [APB_STRB_W-1:0] strb
  );
    logic [APB_DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < APB_STRB_W; i++) begin
      if (strb[i]) begin
        result[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// apb_wait_ctr: loadable down-counter used to time APB wait states.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset (count -> 0)
//   load   in  load count from value (has priority over en)
//   en     in  decrement by one; holds at zero
//   value  in  W-bit load value
//   count  out current count
//   zero   out count == 0
module apb_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Down-counter: load wins, otherwise decrement while enabled and non-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= value;
    end else if (en && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign count = cnt_r;
  assign zero  = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB4 completer holding DEPTH 32-bit byte-strobed registers.
// Inserts WAIT_CYCLES wait states per transfer; misaligned or out-of-bank
// addresses complete with pslverr=1, no write and prdata=0.
// Optional feature macro: APB_PPROT_CHECK_EN -- when defined, transfers with
// pprot[0]=0 (unprivileged) are treated as errors. When undefined pprot is
// latched but has no effect.
// Ports:
//   pclk, preset (async active-low reset)
//   psel, penable, paddr[31:0], pwrite, pprot[2:0], pwdata[31:0], pstrb[3:0]
//   prdata[31:0], pslverr, pready  (all registered, cleared asynchronously)
module apb_regbank_slave
  import apb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_LSB    = 2
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic                  pwrite,
  input  logic [2:0]            pprot,
  input  logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_STRB_W-1:0] pstrb,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pslverr,
  output logic                  pready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_VAL = 4'(WAIT_CYCLES);
  localparam logic [APB_ADDR_W-1:0] LSB_MASK = (32'd1 << ADDR_LSB) - 32'd1;

  apb_state_e            state_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  write_r;
  logic                  err_r;
  logic [2:0]            pprot_r;
  logic [APB_DATA_W-1:0] prdata_r;
  logic                  pslverr_r;
  logic                  pready_r;
  logic [APB_DATA_W-1:0] bank_r [DEPTH];

  logic [IDX_W-1:0] setup_idx_s;
  logic             setup_err_s;
  logic             cnt_load_s;
  logic             cnt_en_s;
  logic [3:0]       cnt_s;
  logic             cnt_zero_s;
  logic             commit_s;
  logic             unused_s;

  // Setup-phase decode: word index and error flag from the live address.
  always_comb begin
    setup_idx_s = paddr[ADDR_LSB +: IDX_W];
    setup_err_s = ((paddr & LSB_MASK) != 32'd0) ||
                  ((paddr >> ADDR_LSB) >= 32'(DEPTH));
`ifdef APB_PPROT_CHECK_EN
    if (!pprot[0]) begin
      setup_err_s = 1'b1;
    end else begin
      setup_err_s = setup_err_s;
    end
`endif
  end

  // Wait counter control: load on setup, count down during held access phase.
  always_comb begin
    cnt_load_s = (state_r == IDLE) && psel && !penable;
    cnt_en_s   = (state_r == ACCESS) && psel && penable && !cnt_zero_s;
  end

  apb_wait_ctr #(.W(4)) u_wait_ctr (
    .clk   (pclk),
    .rst_n (preset),
    .load  (cnt_load_s),
    .en    (cnt_en_s),
    .value (WAIT_VAL),
    .count (cnt_s),
    .zero  (cnt_zero_s)
  );

  // Completer FSM; outputs are registered one cycle ahead so pready is high
  // exactly while state is ACCESS with the wait counter at zero.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      write_r   <= 1'b0;
      err_r     <= 1'b0;
      pprot_r   <= 3'b000;
      prdata_r  <= 32'h0;
      pslverr_r <= 1'b0;
      pready_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          prdata_r  <= 32'h0;
          pslverr_r <= 1'b0;
          pready_r  <= 1'b0;
          if (psel && !penable) begin
            state_r <= ACCESS;
            idx_r   <= setup_idx_s;
            write_r <= pwrite;
            err_r   <= setup_err_s;
            pprot_r <= pprot;
            if (WAIT_VAL == 4'd0) begin
              pready_r  <= 1'b1;
              pslverr_r <= setup_err_s;
              prdata_r  <= (!pwrite && !setup_err_s) ? bank_r[setup_idx_s] : 32'h0;
            end else begin
              pready_r  <= 1'b0;
            end
          end else begin
            // psel&&penable here is a protocol violation: ignore it.
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_zero_s) begin
            state_r   <= IDLE;
            prdata_r  <= 32'h0;
            pslverr_r <= 1'b0;
            pready_r  <= 1'b0;
          end else if (psel && penable) begin
            state_r <= ACCESS;
            if (cnt_s == 4'd1) begin
              pready_r  <= 1'b1;
              pslverr_r <= err_r;
              prdata_r  <= (!write_r && !err_r) ? bank_r[idx_r] : 32'h0;
            end else begin
              pready_r  <= 1'b0;
              pslverr_r <= 1'b0;
              prdata_r  <= 32'h0;
            end
          end else begin
            // Master abandoned the transfer mid-wait: no side effects.
            state_r   <= IDLE;
            prdata_r  <= 32'h0;
            pslverr_r <= 1'b0;
            pready_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          prdata_r  <= 32'h0;
          pslverr_r <= 1'b0;
          pready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign commit_s = (state_r == ACCESS) && pready_r && psel && penable && write_r && !err_r;

  // Register bank with byte-strobed write on the completing edge.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_r[i] <= 32'h0;
      end
    end else if (commit_s) begin
      bank_r[idx_r] <= merge_bytes(bank_r[idx_r], pwdata, pstrb);
    end else begin
      bank_r[idx_r] <= bank_r[idx_r];
    end
  end

  // pprot is captured for the whole access but only feeds decode when checked.
  assign unused_s = ^pprot_r;

  assign prdata  = prdata_r;
  assign pslverr = pslverr_r;
  assign pready  = pready_r;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Directed bench for apb_regbank_slave (DEPTH=16, WAIT_CYCLES=1, ADDR_LSB=2).
module tb_apb_regbank_slave;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pslverr;
  logic        pready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rd;
  logic        er;
  int          cyc;
  logic [31:0] prot_err_exp;
  logic [31:0] prot_rd_exp;

  apb_regbank_slave #(.DEPTH(16), .WAIT_CYCLES(1), .ADDR_LSB(2)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .pprot   (pprot),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pslverr (pslverr),
    .pready  (pready)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete APB transfer; returns read data, error and access-cycle count.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          output logic [31:0] rdata, output logic err, output int ncyc);
    bit done;
    done = 1'b0;
    ncyc = 0;
    rdata = 32'h0;
    err = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
    pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge pclk); #1;
    penable = 1'b1;
    while (!done && ncyc < 20) begin
      @(negedge pclk);
      ncyc++;
      if (pready) begin
        rdata = prdata;
        err = pslverr;
        done = 1'b1;
      end else begin
        check("pslverr_low_while_waiting", {31'h0, pslverr}, 32'h0);
      end
    end
    if (!done) check("pready_timeout", 32'h0, 32'h1);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
`ifdef APB_PPROT_CHECK_EN
    prot_err_exp = 32'h1;
    prot_rd_exp  = 32'h0;
`else
    prot_err_exp = 32'h0;
    prot_rd_exp  = 32'hA5A5A5A5;
`endif
    preset = 1'b0; psel = 1'b0; penable = 1'b0; paddr = 32'h0; pwrite = 1'b0;
    pprot = 3'b001; pwdata = 32'h0; pstrb = 4'h0;
    #23;
    check("reset_pready", {31'h0, pready}, 32'h0);
    check("reset_pslverr", {31'h0, pslverr}, 32'h0);
    check("reset_prdata", prdata, 32'h0);
    @(negedge pclk); preset = 1'b1;

    // 1: async reset while an error read is completing (pready/pslverr high)
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h40; pwrite = 1'b0;
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk); @(negedge pclk);
    check("pre_reset_pready", {31'h0, pready}, 32'h1);
    check("pre_reset_pslverr", {31'h0, pslverr}, 32'h1);
    #1 preset = 1'b0;
    #1;
    check("async_reset_pready", {31'h0, pready}, 32'h0);
    check("async_reset_pslverr", {31'h0, pslverr}, 32'h0);
    check("async_reset_prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk); preset = 1'b1;
    apb_xfer(32'h08, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("read08_after_reset", rd, 32'h0);

    // 2: full write and readback, one wait state
    apb_xfer(32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, cyc);
    check("wr04_cycles", 32'(cyc), 32'd2);
    check("wr04_err", {31'h0, er}, 32'h0);
    apb_xfer(32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("rd04_data", rd, 32'hDEADBEEF);
    check("rd04_cycles", 32'(cyc), 32'd2);

    // 3: partial strobe write
    apb_xfer(32'h04, 1'b1, 32'h11223344, 4'b0101, 3'b001, rd, er, cyc);
    apb_xfer(32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("partial_rd04", rd, 32'hDE22BE44);

    // pstrb=0 is a legal no-op
    apb_xfer(32'h04, 1'b1, 32'hFFFFFFFF, 4'h0, 3'b001, rd, er, cyc);
    check("nostrb_err", {31'h0, er}, 32'h0);
    apb_xfer(32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("nostrb_rd04", rd, 32'hDE22BE44);

    // 4: errors: out-of-bank read and misaligned write
    apb_xfer(32'h40, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("rd40_err", {31'h0, er}, 32'h1);
    check("rd40_data", rd, 32'h0);
    check("rd40_cycles", 32'(cyc), 32'd2);
    apb_xfer(32'h06, 1'b1, 32'h99999999, 4'hF, 3'b001, rd, er, cyc);
    check("wr06_err", {31'h0, er}, 32'h1);
    apb_xfer(32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("after_err_rd04_err", {31'h0, er}, 32'h0);
    check("after_err_rd04_data", rd, 32'hDE22BE44);

    // last word of the bank
    apb_xfer(32'h3C, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, rd, er, cyc);
    apb_xfer(32'h3C, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("rd3c_data", rd, 32'hCAFEF00D);
    check("rd3c_err", {31'h0, er}, 32'h0);

    // 5: abort a write by dropping psel during its wait state
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1;
    pwdata = 32'h55AA55AA; pstrb = 4'hF;
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk);
    check("abort_wait_pready", {31'h0, pready}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("abort_after_pready", {31'h0, pready}, 32'h0);
    apb_xfer(32'h0C, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("abort_rd0c", rd, 32'h0);

    // 6: privilege check (behaviour depends on APB_PPROT_CHECK_EN)
    apb_xfer(32'h00, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b000, rd, er, cyc);
    check("unpriv_wr_err", {31'h0, er}, prot_err_exp);
    apb_xfer(32'h00, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("unpriv_rd00", rd, prot_rd_exp);
    apb_xfer(32'h00, 1'b1, 32'h5A5A5A5A, 4'hF, 3'b001, rd, er, cyc);
    check("priv_wr_err", {31'h0, er}, 32'h0);
    apb_xfer(32'h00, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("priv_rd00", rd, 32'h5A5A5A5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
